// File: rtl/mem_tg_axi_responder_if.sv
// ofs_fim_emif_axi_mm_if: AXI4 memory-mapped channel between the traffic
// generator (manager, modport "user") and the EMIF side (subordinate,
// modport "emif").
// Parameters: ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH.
// clk/rst_n are carried for agents that want them; the responder uses its
// own clock and reset ports instead.
interface ofs_fim_emif_axi_mm_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 1
);
  logic                    clk;
  logic                    rst_n;

  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [USER_WIDTH-1:0]   awuser;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;

  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [USER_WIDTH-1:0]   aruser;

  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;

  modport emif (
    input  clk, rst_n,
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp, buser,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser,
    output arready,
    output rvalid, rid, rdata, rresp, rlast, ruser,
    input  rready
  );

  modport user (
    input  clk, rst_n,
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp, buser,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast, ruser,
    output rready
  );
endinterface

// File: rtl/mem_tg_axi_responder.sv
// mem_tg_axi_responder: AXI4 subordinate that stands in for an EMIF channel.
// Stores bursts in an internal word array and answers reads after a fixed
// programmable latency. One outstanding burst per direction; the read and
// write paths run independently.
//
// Ports:
//   clk          single clock
//   rst_n        synchronous active-low reset
//   s_if         AXI subordinate port (ofs_fim_emif_axi_mm_if.emif)
//   wr_beat_cnt  accepted W beats (wraps)
//   rd_beat_cnt  completed R beats (wraps)
//   proto_err    sticky wlast-mismatch flag
//   rng_err_cnt  saturating count of out-of-range bursts
//
// Optional feature: define MEM_TG_RESP_RANGE_CHK_EN to flag bursts whose
// start address lies beyond the array. Without it, upper address bits alias.
//
// state   | meaning
// WR_IDLE | awready high, waiting for a write address
// WR_DATA | wready high, absorbing beats until beat count reaches awlen
// WR_RESP | bvalid high until bready
// RD_IDLE | arready high, waiting for a read address
// RD_WAIT | counting down the read latency
// RD_DATA | rvalid high, streaming beats until the rlast handshake
module mem_tg_axi_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 512,
  parameter int ID_WIDTH       = 8,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ofs_fim_emif_axi_mm_if.emif s_if,
  output logic [31:0]         wr_beat_cnt,
  output logic [31:0]         rd_beat_cnt,
  output logic                proto_err,
  output logic [15:0]         rng_err_cnt
);
  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << MEM_DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(RD_LATENCY - 1);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];

  wr_state_t                 r_wr_state;
  logic                      r_awready, r_wready, r_bvalid;
  logic [1:0]                r_bresp;
  logic [ID_WIDTH-1:0]       r_bid;
  logic [MEM_DEPTH_LOG2-1:0] r_wr_idx;
  logic [7:0]                r_wr_len, r_wr_beat;
  logic                      r_wr_err, r_wr_oor, r_proto_err;
  logic [31:0]               r_wr_beat_cnt;

  rd_state_t                 r_rd_state;
  logic                      r_arready, r_rvalid, r_rlast;
  logic [1:0]                r_rresp;
  logic [ID_WIDTH-1:0]       r_rid;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [MEM_DEPTH_LOG2-1:0] r_rd_idx;
  logic [7:0]                r_rd_len, r_rd_beat;
  logic [3:0]                r_rd_wait;
  logic                      r_rd_oor;
  logic [31:0]               r_rd_beat_cnt;

  logic [MEM_DEPTH_LOG2-1:0] w_aw_idx, w_ar_idx, w_ld_idx;
  logic                      w_aw_oor, w_ar_oor, w_ld_oor;
  logic                      w_aw_fire, w_ar_fire, w_wr_fire, w_wr_final, w_wlast_bad;

  assign w_aw_idx    = s_if.awaddr[ADDR_LSB +: MEM_DEPTH_LOG2];
  assign w_ar_idx    = s_if.araddr[ADDR_LSB +: MEM_DEPTH_LOG2];
  assign w_aw_fire   = r_awready && s_if.awvalid;
  assign w_ar_fire   = r_arready && s_if.arvalid;
  assign w_wr_fire   = r_wready && s_if.wvalid;
  assign w_wr_final  = (r_wr_beat == r_wr_len);
  assign w_wlast_bad = (s_if.wlast != w_wr_final);

`ifdef MEM_TG_RESP_RANGE_CHK_EN
  logic [15:0] r_rng_err_cnt;
  logic [16:0] w_rng_sum;

  assign w_aw_oor  = (s_if.awaddr >> (ADDR_LSB + MEM_DEPTH_LOG2)) != '0;
  assign w_ar_oor  = (s_if.araddr >> (ADDR_LSB + MEM_DEPTH_LOG2)) != '0;
  // Both directions can flag a burst in the same cycle.
  assign w_rng_sum = {1'b0, r_rng_err_cnt} + 17'(w_aw_fire && w_aw_oor)
                   + 17'(w_ar_fire && w_ar_oor);

  always_ff @(posedge clk) begin
    if (!rst_n)            r_rng_err_cnt <= '0;
    else if (w_rng_sum[16]) r_rng_err_cnt <= '1;
    else                   r_rng_err_cnt <= w_rng_sum[15:0];
  end
  assign rng_err_cnt = r_rng_err_cnt;
`else
  assign w_aw_oor    = 1'b0;
  assign w_ar_oor    = 1'b0;
  assign rng_err_cnt = '0;
`endif

  // Array write; no reset on contents.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_fire && !r_wr_oor) begin
      for (int b = 0; b < NBYTES; b++)
        if (s_if.wstrb[b]) r_mem[r_wr_idx][b*8 +: 8] <= s_if.wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state    <= WR_IDLE;
      r_awready     <= 1'b0;
      r_wready      <= 1'b0;
      r_bvalid      <= 1'b0;
      r_bresp       <= OKAY;
      r_bid         <= '0;
      r_wr_idx      <= '0;
      r_wr_len      <= '0;
      r_wr_beat     <= '0;
      r_wr_err      <= 1'b0;
      r_wr_oor      <= 1'b0;
      r_proto_err   <= 1'b0;
      r_wr_beat_cnt <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_fire) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_bid      <= s_if.awid;
            r_wr_idx   <= w_aw_idx;
            r_wr_len   <= s_if.awlen;
            r_wr_beat  <= '0;
            r_wr_err   <= 1'b0;
            r_wr_oor   <= w_aw_oor;
            r_wr_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_wr_fire) begin
            r_wr_idx      <= r_wr_idx + 1'b1;
            r_wr_beat     <= r_wr_beat + 8'd1;
            r_wr_beat_cnt <= r_wr_beat_cnt + 32'd1;
            if (w_wlast_bad) begin
              r_wr_err    <= 1'b1;
              r_proto_err <= 1'b1;
            end
            // Beat count, not wlast, ends the burst.
            if (w_wr_final) begin
              r_wready   <= 1'b0;
              r_bvalid   <= 1'b1;
              r_bresp    <= (r_wr_err || w_wlast_bad || r_wr_oor) ? SLVERR : OKAY;
              r_wr_state <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_if.bready) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Word to stage into the read-data register: the start word while idle
  // (covers zero latency), the start word while waiting, the next word while
  // streaming.
  always_comb begin
    w_ld_idx = r_rd_idx;
    w_ld_oor = r_rd_oor;
    case (r_rd_state)
      RD_IDLE: begin
        w_ld_idx = w_ar_idx;
        w_ld_oor = w_ar_oor;
      end
      RD_DATA: w_ld_idx = r_rd_idx + 1'b1;
      default: w_ld_idx = r_rd_idx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state    <= RD_IDLE;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rlast       <= 1'b0;
      r_rresp       <= OKAY;
      r_rid         <= '0;
      r_rdata       <= '0;
      r_rd_idx      <= '0;
      r_rd_len      <= '0;
      r_rd_beat     <= '0;
      r_rd_wait     <= '0;
      r_rd_oor      <= 1'b0;
      r_rd_beat_cnt <= '0;
    end else begin
      if (!r_rvalid || s_if.rready)
        r_rdata <= w_ld_oor ? '0 : r_mem[w_ld_idx];
      case (r_rd_state)
        RD_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_fire) begin
            r_arready <= 1'b0;
            r_rid     <= s_if.arid;
            r_rd_idx  <= w_ar_idx;
            r_rd_len  <= s_if.arlen;
            r_rd_beat <= '0;
            r_rd_oor  <= w_ar_oor;
            r_rresp   <= w_ar_oor ? SLVERR : OKAY;
            if (RD_LATENCY == 0) begin
              r_rvalid   <= 1'b1;
              r_rlast    <= (s_if.arlen == 8'd0);
              r_rd_state <= RD_DATA;
            end else begin
              r_rd_wait  <= LAT_M1;
              r_rd_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (r_rd_wait == 4'd0) begin
            r_rvalid   <= 1'b1;
            r_rlast    <= (r_rd_len == 8'd0);
            r_rd_state <= RD_DATA;
          end else begin
            r_rd_wait <= r_rd_wait - 4'd1;
          end
        end
        RD_DATA: begin
          if (s_if.rready) begin
            r_rd_beat_cnt <= r_rd_beat_cnt + 32'd1;
            if (r_rlast) begin
              r_rvalid   <= 1'b0;
              r_rlast    <= 1'b0;
              r_arready  <= 1'b1;
              r_rd_state <= RD_IDLE;
            end else begin
              r_rd_idx  <= r_rd_idx + 1'b1;
              r_rd_beat <= r_rd_beat + 8'd1;
              r_rlast   <= ((r_rd_beat + 8'd1) == r_rd_len);
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign s_if.awready = r_awready;
  assign s_if.wready  = r_wready;
  assign s_if.bvalid  = r_bvalid;
  assign s_if.bid     = r_bid;
  assign s_if.bresp   = r_bresp;
  assign s_if.buser   = '0;
  assign s_if.arready = r_arready;
  assign s_if.rvalid  = r_rvalid;
  assign s_if.rid     = r_rid;
  assign s_if.rdata   = r_rdata;
  assign s_if.rresp   = r_rresp;
  assign s_if.rlast   = r_rlast;
  assign s_if.ruser   = '0;

  assign wr_beat_cnt = r_wr_beat_cnt;
  assign rd_beat_cnt = r_rd_beat_cnt;
  assign proto_err   = r_proto_err;
endmodule

// File: tb/tb_mem_tg_axi_responder.sv
module tb_mem_tg_axi_responder;
  localparam int DW = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wr_beat_cnt, rd_beat_cnt;
  logic        proto_err;
  logic [15:0] rng_err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  // Observations gathered by the transaction tasks.
  bit         obs_timeout;
  logic       obs_wready_after_aw, obs_bvalid_after_w, obs_bvalid_held;
  logic       obs_awready_after_b, obs_bvalid_after_b;
  logic [1:0] obs_bresp;
  logic [7:0] obs_bid;
  int         obs_lat, obs_nbeats, obs_data_bad, obs_rlast_bad;
  logic [1:0] obs_rresp;
  logic [7:0] obs_rid;
  logic       obs_rvalid_after;

  always #5 clk = ~clk;

  ofs_fim_emif_axi_mm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .ID_WIDTH(8), .USER_WIDTH(1)) u_if ();
  assign u_if.clk   = clk;
  assign u_if.rst_n = rst_n;

  mem_tg_axi_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(DW), .ID_WIDTH(8), .MEM_DEPTH_LOG2(10), .RD_LATENCY(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_if(u_if),
    .wr_beat_cnt(wr_beat_cnt),
    .rd_beat_cnt(rd_beat_cnt),
    .proto_err(proto_err),
    .rng_err_cnt(rng_err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id,
                          input logic [7:0] base, input int last_at, input int b_delay);
    int guard;
    obs_timeout = 0;
    u_if.awaddr = addr; u_if.awlen = len; u_if.awid = id; u_if.awvalid = 1'b1;
    guard = 0;
    while (!u_if.awready && guard < 50) begin step(); guard++; end
    if (guard >= 50) obs_timeout = 1;
    step();
    u_if.awvalid = 1'b0;
    obs_wready_after_aw = u_if.wready;
    for (int i = 0; i <= int'(len); i++) begin
      u_if.wdata = '0;
      u_if.wdata[7:0] = base + 8'(i);
      u_if.wstrb = '1;
      u_if.wlast = (last_at < 0) ? (i == int'(len)) : (i == last_at);
      u_if.wvalid = 1'b1;
      guard = 0;
      while (!u_if.wready && guard < 50) begin step(); guard++; end
      if (guard >= 50) obs_timeout = 1;
      step();
    end
    u_if.wvalid = 1'b0;
    u_if.wlast  = 1'b0;
    obs_bvalid_after_w = u_if.bvalid;
    obs_bvalid_held = 1'b1;
    for (int k = 0; k < b_delay; k++) begin
      step();
      if (!u_if.bvalid) obs_bvalid_held = 1'b0;
    end
    guard = 0;
    while (!u_if.bvalid && guard < 50) begin step(); guard++; end
    if (guard >= 50) obs_timeout = 1;
    obs_bresp = u_if.bresp;
    obs_bid   = u_if.bid;
    u_if.bready = 1'b1;
    step();
    u_if.bready = 1'b0;
    obs_awready_after_b = u_if.awready;
    obs_bvalid_after_b  = u_if.bvalid;
  endtask

  // exp_zero: every beat must read as zero; otherwise beat i carries base+i.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id,
                         input logic [7:0] base, input bit exp_zero, input logic [3:0] pat);
    int guard, c, nb;
    logic [DW-1:0] exp_d;
    obs_timeout = 0; obs_data_bad = 0; obs_rlast_bad = 0;
    obs_rresp = 2'bxx; obs_rid = 8'hxx;
    u_if.araddr = addr; u_if.arlen = len; u_if.arid = id; u_if.arvalid = 1'b1;
    guard = 0;
    while (!u_if.arready && guard < 50) begin step(); guard++; end
    if (guard >= 50) obs_timeout = 1;
    step();
    u_if.arvalid = 1'b0;
    obs_lat = 1;
    guard = 0;
    while (!u_if.rvalid && guard < 50) begin step(); obs_lat++; guard++; end
    if (guard >= 50) obs_timeout = 1;
    c = 0; nb = 0; guard = 0;
    while (nb <= int'(len) && guard < 200) begin
      u_if.rready = pat[c % 4];
      if (u_if.rvalid) begin
        exp_d = '0;
        if (!exp_zero) exp_d[7:0] = base + 8'(nb);
        if (u_if.rdata !== exp_d) obs_data_bad++;
        if (u_if.rlast !== (nb == int'(len))) obs_rlast_bad++;
        obs_rresp = u_if.rresp;
        obs_rid   = u_if.rid;
        if (u_if.rready) nb++;
      end
      step();
      c++; guard++;
    end
    if (guard >= 200) obs_timeout = 1;
    u_if.rready = 1'b0;
    obs_nbeats = nb;
    obs_rvalid_after = u_if.rvalid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++; if (u_if.awready !== 1'b0) begin n_errors++; $display("FAIL reset_awready got=%b exp=0", u_if.awready); end
    n_checks++; if (u_if.arready !== 1'b0) begin n_errors++; $display("FAIL reset_arready got=%b exp=0", u_if.arready); end
    n_checks++; if (u_if.wready !== 1'b0) begin n_errors++; $display("FAIL reset_wready got=%b exp=0", u_if.wready); end
    n_checks++; if (u_if.bvalid !== 1'b0 || u_if.rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_valids got=%b%b exp=00", u_if.bvalid, u_if.rvalid); end
    n_checks++; if (wr_beat_cnt !== 32'd0 || rd_beat_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", wr_beat_cnt, rd_beat_cnt); end
    n_checks++; if (proto_err !== 1'b0 || rng_err_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_errs got=%b/%0d exp=0/0", proto_err, rng_err_cnt); end
    rst_n = 1'b1;
    step();
    n_checks++; if (u_if.awready !== 1'b1 || u_if.arready !== 1'b1) begin n_errors++; $display("FAIL release_readies got=%b%b exp=11", u_if.awready, u_if.arready); end
  endtask

  task automatic test_w_before_aw();
    u_if.wvalid = 1'b1; u_if.wdata = '1; u_if.wstrb = '1; u_if.wlast = 1'b1;
    repeat (3) begin
      step();
      n_checks++; if (u_if.wready !== 1'b0) begin n_errors++; $display("FAIL w_stall_wready got=%b exp=0", u_if.wready); end
    end
    u_if.wvalid = 1'b0; u_if.wlast = 1'b0;
    n_checks++; if (wr_beat_cnt !== 32'd0) begin n_errors++; $display("FAIL w_stall_cnt got=%0d exp=0", wr_beat_cnt); end
  endtask

  task automatic test_write_burst();
    do_write(32'h40, 8'd3, 8'h11, 8'hA0, -1, 0);
    exp_wr += 4;
    n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL wr_timeout got=1 exp=0"); end
    n_checks++; if (obs_wready_after_aw !== 1'b1) begin n_errors++; $display("FAIL wr_wready_t1 got=%b exp=1", obs_wready_after_aw); end
    n_checks++; if (obs_bvalid_after_w !== 1'b1) begin n_errors++; $display("FAIL wr_bvalid_t1 got=%b exp=1", obs_bvalid_after_w); end
    n_checks++; if (obs_bresp !== 2'b00) begin n_errors++; $display("FAIL wr_bresp got=%b exp=00", obs_bresp); end
    n_checks++; if (obs_bid !== 8'h11) begin n_errors++; $display("FAIL wr_bid got=%h exp=11", obs_bid); end
    n_checks++; if (wr_beat_cnt !== 32'(exp_wr)) begin n_errors++; $display("FAIL wr_beat_cnt got=%0d exp=%0d", wr_beat_cnt, exp_wr); end
    n_checks++; if (obs_awready_after_b !== 1'b1 || obs_bvalid_after_b !== 1'b0) begin n_errors++; $display("FAIL wr_b2b_awready got=%b/%b exp=1/0", obs_awready_after_b, obs_bvalid_after_b); end
  endtask

  task automatic test_read_burst();
    do_read(32'h40, 8'd3, 8'h22, 8'hA0, 1'b0, 4'b1111);
    exp_rd += 4;
    n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL rd_timeout got=1 exp=0"); end
    n_checks++; if (obs_lat != 3) begin n_errors++; $display("FAIL rd_latency got=%0d exp=3", obs_lat); end
    n_checks++; if (obs_data_bad != 0) begin n_errors++; $display("FAIL rd_data bad_cycles=%0d exp=0", obs_data_bad); end
    n_checks++; if (obs_rlast_bad != 0) begin n_errors++; $display("FAIL rd_rlast bad_cycles=%0d exp=0", obs_rlast_bad); end
    n_checks++; if (obs_rresp !== 2'b00 || obs_rid !== 8'h22) begin n_errors++; $display("FAIL rd_resp_id got=%b/%h exp=00/22", obs_rresp, obs_rid); end
    n_checks++; if (rd_beat_cnt !== 32'(exp_rd)) begin n_errors++; $display("FAIL rd_beat_cnt got=%0d exp=%0d", rd_beat_cnt, exp_rd); end
    n_checks++; if (obs_rvalid_after !== 1'b0 || obs_nbeats != 4) begin n_errors++; $display("FAIL rd_extra_beat rvalid=%b beats=%0d exp=0/4", obs_rvalid_after, obs_nbeats); end
  endtask

  task automatic test_read_stall();
    do_read(32'h40, 8'd3, 8'h23, 8'hA0, 1'b0, 4'b1001);
    exp_rd += 4;
    n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL stall_timeout got=1 exp=0"); end
    n_checks++; if (obs_data_bad != 0) begin n_errors++; $display("FAIL stall_data bad_cycles=%0d exp=0", obs_data_bad); end
    n_checks++; if (obs_rlast_bad != 0) begin n_errors++; $display("FAIL stall_rlast bad_cycles=%0d exp=0", obs_rlast_bad); end
    n_checks++; if (rd_beat_cnt !== 32'(exp_rd) || obs_rvalid_after !== 1'b0) begin n_errors++; $display("FAIL stall_beats got=%0d/%b exp=%0d/0", rd_beat_cnt, obs_rvalid_after, exp_rd); end
  endtask

  task automatic test_proto_err();
    do_write(32'h100, 8'd3, 8'h33, 8'hC0, 1, 2);
    exp_wr += 4;
    n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL perr_timeout got=1 exp=0"); end
    n_checks++; if (wr_beat_cnt !== 32'(exp_wr)) begin n_errors++; $display("FAIL perr_beats got=%0d exp=%0d", wr_beat_cnt, exp_wr); end
    n_checks++; if (obs_bresp !== 2'b10) begin n_errors++; $display("FAIL perr_bresp got=%b exp=10", obs_bresp); end
    n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL perr_flag got=%b exp=1", proto_err); end
    n_checks++; if (obs_bvalid_held !== 1'b1) begin n_errors++; $display("FAIL perr_bvalid_hold got=%b exp=1", obs_bvalid_held); end
    do_read(32'h100, 8'd3, 8'h34, 8'hC0, 1'b0, 4'b1111);
    exp_rd += 4;
    n_checks++; if (obs_data_bad != 0 || obs_timeout) begin n_errors++; $display("FAIL perr_readback bad_cycles=%0d timeout=%0b exp=0/0", obs_data_bad, obs_timeout); end
  endtask

  task automatic test_wrap();
    do_write(32'hFFC0, 8'd1, 8'h44, 8'hB0, -1, 0);
    exp_wr += 2;
    n_checks++; if (obs_bresp !== 2'b00 || obs_timeout) begin n_errors++; $display("FAIL wrap_bresp got=%b timeout=%0b exp=00/0", obs_bresp, obs_timeout); end
    n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL wrap_sticky got=%b exp=1", proto_err); end
    do_read(32'hFFC0, 8'd1, 8'h45, 8'hB0, 1'b0, 4'b1111);
    exp_rd += 2;
    n_checks++; if (obs_data_bad != 0 || obs_rlast_bad != 0) begin n_errors++; $display("FAIL wrap_read data=%0d rlast=%0d exp=0/0", obs_data_bad, obs_rlast_bad); end
    do_read(32'h0, 8'd0, 8'h46, 8'hB1, 1'b0, 4'b1111);
    exp_rd += 1;
    n_checks++; if (obs_data_bad != 0 || obs_rlast_bad != 0) begin n_errors++; $display("FAIL wrap_word0 data=%0d rlast=%0d exp=0/0", obs_data_bad, obs_rlast_bad); end
    n_checks++; if (rd_beat_cnt !== 32'(exp_rd)) begin n_errors++; $display("FAIL wrap_rd_cnt got=%0d exp=%0d", rd_beat_cnt, exp_rd); end
  endtask

  task automatic test_range();
`ifdef MEM_TG_RESP_RANGE_CHK_EN
    do_read(32'h1 << 16, 8'd0, 8'h55, 8'h00, 1'b1, 4'b1111);
    exp_rd += 1;
    n_checks++; if (obs_rresp !== 2'b10) begin n_errors++; $display("FAIL range_rresp got=%b exp=10", obs_rresp); end
    n_checks++; if (obs_data_bad != 0) begin n_errors++; $display("FAIL range_rdata bad_cycles=%0d exp=0", obs_data_bad); end
    n_checks++; if (rng_err_cnt !== 16'd1) begin n_errors++; $display("FAIL range_cnt got=%0d exp=1", rng_err_cnt); end
`else
    do_read(32'h1 << 16, 8'd0, 8'h55, 8'hB1, 1'b0, 4'b1111);
    exp_rd += 1;
    n_checks++; if (obs_rresp !== 2'b00) begin n_errors++; $display("FAIL alias_rresp got=%b exp=00", obs_rresp); end
    n_checks++; if (obs_data_bad != 0) begin n_errors++; $display("FAIL alias_rdata bad_cycles=%0d exp=0", obs_data_bad); end
    n_checks++; if (rng_err_cnt !== 16'd0) begin n_errors++; $display("FAIL alias_cnt got=%0d exp=0", rng_err_cnt); end
`endif
    n_checks++; if (rd_beat_cnt !== 32'(exp_rd) || obs_timeout) begin n_errors++; $display("FAIL range_rd_cnt got=%0d timeout=%0b exp=%0d/0", rd_beat_cnt, obs_timeout, exp_rd); end
  endtask

  task automatic test_reset_mid_burst();
    u_if.awaddr = 32'h80; u_if.awlen = 8'd3; u_if.awid = 8'h66; u_if.awvalid = 1'b1;
    step();
    u_if.awvalid = 1'b0;
    u_if.wdata = '0; u_if.wstrb = '1; u_if.wlast = 1'b0; u_if.wvalid = 1'b1;
    step();
    u_if.wvalid = 1'b0;
    rst_n = 1'b0;
    step();
    n_checks++; if (u_if.wready !== 1'b0 || u_if.bvalid !== 1'b0 || u_if.awready !== 1'b0) begin n_errors++; $display("FAIL midrst_outputs got=%b%b%b exp=000", u_if.wready, u_if.bvalid, u_if.awready); end
    n_checks++; if (proto_err !== 1'b0 || wr_beat_cnt !== 32'd0 || rd_beat_cnt !== 32'd0) begin n_errors++; $display("FAIL midrst_state got=%b/%0d/%0d exp=0/0/0", proto_err, wr_beat_cnt, rd_beat_cnt); end
    rst_n = 1'b1;
    step();
    n_checks++; if (u_if.awready !== 1'b1 || u_if.bvalid !== 1'b0) begin n_errors++; $display("FAIL midrst_idle got=%b/%b exp=1/0", u_if.awready, u_if.bvalid); end
    do_write(32'h80, 8'd0, 8'h67, 8'hD0, -1, 0);
    n_checks++; if (obs_bresp !== 2'b00 || obs_bid !== 8'h67 || wr_beat_cnt !== 32'd1) begin n_errors++; $display("FAIL midrst_write got=%b/%h/%0d exp=00/67/1", obs_bresp, obs_bid, wr_beat_cnt); end
    do_read(32'h80, 8'd0, 8'h68, 8'hD0, 1'b0, 4'b1111);
    n_checks++; if (obs_data_bad != 0 || obs_timeout || rd_beat_cnt !== 32'd1) begin n_errors++; $display("FAIL midrst_read bad=%0d timeout=%0b cnt=%0d exp=0/0/1", obs_data_bad, obs_timeout, rd_beat_cnt); end
  endtask

  initial begin
    u_if.awvalid = 0; u_if.awid = '0; u_if.awaddr = '0; u_if.awlen = '0; u_if.awsize = 3'd6;
    u_if.awburst = 2'b01; u_if.awlock = 0; u_if.awcache = '0; u_if.awprot = '0; u_if.awuser = '0;
    u_if.wvalid = 0; u_if.wdata = '0; u_if.wstrb = '0; u_if.wlast = 0; u_if.bready = 0;
    u_if.arvalid = 0; u_if.arid = '0; u_if.araddr = '0; u_if.arlen = '0; u_if.arsize = 3'd6;
    u_if.arburst = 2'b01; u_if.arlock = 0; u_if.arcache = '0; u_if.arprot = '0; u_if.aruser = '0;
    u_if.rready = 0;
    test_reset();
    test_w_before_aw();
    test_write_burst();
    test_read_burst();
    test_read_stall();
    test_proto_err();
    test_wrap();
    test_range();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
